lvds_tx: RTL and testbench

LVDS_TX -- requirements
Module: lvds_tx

---
 rtl/lvds_tx_pkg.sv | 36 +++
 rtl/lvds_tx_iq_frame_shifter.sv | 39 +++
 rtl/lvds_tx.sv | 89 ++++++++
 tb/tb_lvds_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared constants, state encoding and word framing for the LVDS transmit path.
// Framing forces sync pairs and clears control bits; I and Q payload bits pass through.
package lvds_tx_pkg;

  localparam int IQ_W          = 32;
  localparam int SYMS_PER_WORD = 16;
  localparam int PHASE_W       = $clog2(SYMS_PER_WORD);

  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;

  localparam int SYNC_I_MSB = 31;
  localparam int CTRL_I_BIT = 16;
  localparam int SYNC_Q_MSB = 15;
  localparam int CTRL_Q_BIT = 0;

  localparam logic [PHASE_W-1:0] PULL_PHASE = PHASE_W'(SYMS_PER_WORD - 2);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SYMS_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TX   = 2'd2
  } tx_state_e;

  function automatic logic [IQ_W-1:0] frame_word(input logic [IQ_W-1:0] w);
    logic [IQ_W-1:0] f;
    f                  = w;
    f[SYNC_I_MSB -: 2] = SYNC_I;
    f[CTRL_I_BIT]      = 1'b0;
    f[SYNC_Q_MSB -: 2] = SYNC_Q;
    f[CTRL_Q_BIT]      = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/lvds_tx_iq_frame_shifter.sv
// Holds the framed word being serialised, MSB pair first, plus the symbol phase counter.
// Clear has priority over load, load over shift.
module iq_frame_shifter
  import lvds_tx_pkg::*;
(
  input  logic               i_ddr_clk,
  input  logic               i_rst_b,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic               i_clear,
  input  logic [IQ_W-1:0]    i_data,
  output logic [1:0]         o_sym,
  output logic [PHASE_W-1:0] o_phase
);

  logic [IQ_W-1:0]    r_shift;
  logic [PHASE_W-1:0] r_phase;

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_shift <= '0;
      r_phase <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_phase <= '0;
    end else if (i_load) begin
      r_shift <= frame_word(i_data);
      r_phase <= '0;
    end else if (i_shift) begin
      r_shift <= {r_shift[IQ_W-3:0], 2'b00};
      r_phase <= r_phase + PHASE_W'(1);
    end
  end

  // The output pair comes straight from the register, so it is glitch-free for the DDR cell.
  assign o_sym   = r_shift[IQ_W-1 -: 2];
  assign o_phase = r_phase;

endmodule

// File: rtl/lvds_tx.sv
// LVDS transmit control: FIFO handshake and IDLE/LOAD/TX sequencing around the frame shifter.
// The next word is pulled at phase 14 so it can be loaded at phase 15 without a gap.
module lvds_tx
  import lvds_tx_pkg::*;
(
  input  logic            i_ddr_clk,
  input  logic            i_rst_b,
  input  logic            i_tx_en,
  input  logic            i_fifo_empty,
  input  logic [IQ_W-1:0] i_fifo_data,
  output logic            o_fifo_pull,
  output logic [1:0]      o_ddr_data,
  output logic            o_busy,
  output logic            o_underrun,
  output logic [1:0]      o_debug_state
);

  tx_state_e          r_state;
  logic               r_pending;
  logic               r_underrun;
  logic [PHASE_W-1:0] w_phase;
  logic               w_can_pull;
  logic               w_at_pull;
  logic               w_at_last;
  logic               w_load;
  logic               w_clear;
  logic               w_shift;
  logic               w_bad_state;

  // Gating with i_rst_b keeps the strobe low throughout reset, not just after the first edge.
  assign w_can_pull  = i_rst_b && i_tx_en && !i_fifo_empty;
  assign w_at_pull   = (r_state == ST_TX) && (w_phase == PULL_PHASE);
  assign w_at_last   = (r_state == ST_TX) && (w_phase == LAST_PHASE);
  assign w_bad_state = (r_state != ST_IDLE) && (r_state != ST_LOAD) && (r_state != ST_TX);

  assign o_fifo_pull = w_can_pull && ((r_state == ST_IDLE) || w_at_pull);

  assign w_load  = (r_state == ST_LOAD) || (w_at_last && r_pending);
  assign w_clear = (w_at_last && !r_pending) || w_bad_state;
  assign w_shift = (r_state == ST_TX);

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_pending <= 1'b0;
          if (o_fifo_pull) r_state <= ST_LOAD;
        end
        ST_LOAD: r_state <= ST_TX;
        ST_TX: begin
          if (w_at_pull) begin
            r_pending  <= o_fifo_pull;
            // Enabled but starved at the pull slot: the word in flight is the last one.
            r_underrun <= i_tx_en && i_fifo_empty;
          end
          if (w_at_last) begin
            r_pending <= 1'b0;
            if (!r_pending) r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  iq_frame_shifter u_shifter (
    .i_ddr_clk (i_ddr_clk),
    .i_rst_b   (i_rst_b),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_clear   (w_clear),
    .i_data    (i_fifo_data),
    .o_sym     (o_ddr_data),
    .o_phase   (w_phase)
  );

  assign o_busy        = (r_state == ST_LOAD) || (r_state == ST_TX);
  assign o_underrun    = r_underrun;
  assign o_debug_state = r_state;

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: a schedule-based reference model predicts, per cycle, pulls, symbols,
// busy, state and underrun from the word-level transmit rules; outputs are sampled on the falling edge.
module tb_lvds_tx;

  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        tx_en;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_pull;
  logic [1:0]  ddr_data;
  logic        busy;
  logic        underrun;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  lvds_tx dut (
    .i_ddr_clk     (clk),
    .i_rst_b       (rst_b),
    .i_tx_en       (tx_en),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_data   (fifo_data),
    .o_fifo_pull   (fifo_pull),
    .o_ddr_data    (ddr_data),
    .o_busy        (busy),
    .o_underrun    (underrun),
    .o_debug_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected-value schedule indexed by cycle number.
  int e_sym   [NC];
  int e_busy  [NC];
  int e_state [NC];
  int e_und   [NC];
  int obs_sym [NC];

  logic [31:0] q[$];
  int          starts[$];
  logic [31:0] frames[$];
  int          wptr      = 0;
  logic [31:0] last_word = '0;
  int          next_dec  = 0;
  bit          from_idle = 1'b1;
  bit          in_rst    = 1'b1;
  bit          exp_pull  = 1'b0;

  function automatic logic [31:0] frame_ref(input logic [31:0] w);
    return (w & 32'h3FFE_3FFE) | 32'h8000_4000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Word-level decision: one pull opportunity when idle, and one 14 cycles into each word.
  task automatic model_cycle();
    logic [31:0] f;
    int st;
    exp_pull = 1'b0;
    if (in_rst) return;
    if (cyc == next_dec) begin
      if (tx_en && q.size() > 0) begin
        exp_pull = 1'b1;
        f  = frame_ref(q[0]);
        st = cyc + 2;
        if (from_idle) begin
          e_busy[cyc+1]  = 1;
          e_state[cyc+1] = 1;
        end
        for (int k = 0; k < 16; k++) begin
          e_sym[st+k]   = int'((f >> (30 - 2*k)) & 32'd3);
          e_busy[st+k]  = 1;
          e_state[st+k] = 2;
        end
        starts.push_back(st);
        frames.push_back(f);
        next_dec  = st + 14;
        from_idle = 1'b0;
      end else if (from_idle) begin
        next_dec = cyc + 1;
      end else begin
        if (tx_en) e_und[cyc+1] = 1;
        next_dec  = cyc + 2;
        from_idle = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic [31:0] w;
    @(negedge clk);
    model_cycle();
    chk("pull",     fifo_pull, exp_pull);
    chk("ddr",      ddr_data,  e_sym[cyc]);
    chk("busy",     busy,      e_busy[cyc]);
    chk("state",    dbg_state, e_state[cyc]);
    chk("underrun", underrun,  e_und[cyc]);
    obs_sym[cyc] = ddr_data;
    if (wptr < starts.size() && cyc == starts[wptr] + 15) begin
      w = '0;
      for (int k = 0; k < 16; k++) w = {w[29:0], obs_sym[starts[wptr]+k][1:0]};
      last_word = w;
      $display("word %0d start=%0d frame_seen=%08h frame_model=%08h", wptr, starts[wptr], w, frames[wptr]);
      chk("word", w, frames[wptr]);
      wptr++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (exp_pull) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);
    if (cyc > NC - 40) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 40);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic flush();
    q.delete();
    fifo_empty = 1'b1;
  endtask

  // Assert reset mid-cycle, check outputs collapse at once, hold, then release at a cycle start.
  task automatic do_reset(input int hold);
    #2 rst_b = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("rst_pull",  fifo_pull, 0);
    chk("rst_ddr",   ddr_data,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_state", dbg_state, 0);
    chk("rst_und",   underrun,  0);
    for (int i = cyc; i < NC; i++) begin
      e_sym[i] = 0; e_busy[i] = 0; e_state[i] = 0; e_und[i] = 0;
    end
    while (starts.size() > wptr) begin
      void'(starts.pop_back());
      void'(frames.pop_back());
    end
    repeat (hold) tick();
    rst_b     = 1'b1;
    in_rst    = 1'b0;
    next_dec  = cyc;
    from_idle = 1'b1;
  endtask

  initial begin
    int w0;
    rst_b      = 1'b0;
    tx_en      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;

    $display("step reset");
    repeat (3) tick();
    rst_b = 1'b1; in_rst = 1'b0; next_dec = cyc; from_idle = 1'b1;
    repeat (2) tick();

    $display("step single zero word");
    push(32'h0000_0000); tx_en = 1'b1;
    repeat (20) tick();
    chk("frame_zero", last_word, 32'h8000_4000);
    tx_en = 1'b0;
    repeat (2) tick();

    $display("step all-ones word");
    push(32'hFFFF_FFFF); tx_en = 1'b1;
    repeat (20) tick();
    chk("frame_ones", last_word, 32'hBFFE_7FFE);
    tx_en = 1'b0;
    repeat (2) tick();

    $display("step three back-to-back words");
    w0 = wptr;
    for (int i = 0; i < 3; i++) push($urandom);
    tx_en = 1'b1;
    repeat (52) tick();
    chk("three_words", wptr - w0, 3);
    tx_en = 1'b0;
    repeat (2) tick();

    $display("step enable dropped at phase 5");
    push($urandom); push($urandom); tx_en = 1'b1;
    repeat (7) tick();
    tx_en = 1'b0;
    repeat (15) tick();
    flush();
    repeat (2) tick();

    $display("step reset at phase 7");
    push($urandom); push($urandom); push($urandom); tx_en = 1'b1;
    repeat (9) tick();
    do_reset(2);
    repeat (22) tick();
    tx_en = 1'b0;
    repeat (20) tick();
    flush();
    repeat (2) tick();

    $display("step fifo drained at phase 13");
    push($urandom); push($urandom); tx_en = 1'b1;
    repeat (15) tick();
    flush();
    repeat (6) tick();
    tx_en = 1'b0;
    repeat (2) tick();

    $display("step random traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0 && q.size() < 3) push($urandom);
      if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
      tick();
    end
    tx_en = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
